// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Imported by the fetch interface users and the fetch top.
package if_pkg;

  typedef enum logic [2:0] {F0, F1, F2, F3, CAP, HOLD} fetch_state_e;

  localparam logic [31:0] INSN_BUBBLE      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte lane issued from each issue state; only meaningful in F0..F3.
  function automatic logic [1:0] issue_lane(input fetch_state_e s);
    case (s)
      F1:      return 2'd1;
      F2:      return 2'd2;
      F3:      return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: decode-side redirect/stall, byte memory port and IF/ID outputs.
// master = fetch unit, slave = surrounding pipeline/memory.
interface if_fetch_if;
  logic        stall;
  logic        redir_e;
  logic [31:0] redir_off;
  logic [31:0] redir_base;
  logic        mem_busy;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_re;
  logic [31:0] is;
  logic [31:0] pc;
  logic        vld;

  modport master (
    input  stall, redir_e, redir_off, redir_base, mem_busy, mem_din,
    output mem_a, mem_re, is, pc, vld
  );

  modport slave (
    output stall, redir_e, redir_off, redir_base, mem_busy, mem_din,
    input  mem_a, mem_re, is, pc, vld
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit word from four little-endian byte reads
// and presents it with its link PC for one cycle (held while decode stalls).
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  if_fetch_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  fpc_q;
  logic         pend_q;
  logic [1:0]   pidx_q;
  logic [23:0]  asm_q;
  logic [31:0]  is_q;
  logic [31:0]  pc_q;
  logic         vld_q;

  logic         want_issue;
  logic [1:0]   bidx;
  logic         accept;
  logic [31:0]  fpc_inc_d;
  logic [31:0]  redir_tgt_d;

  always_comb begin
    want_issue = 1'b0;
    case (state_q)
      F0, F1, F2, F3: want_issue = 1'b1;
      default:        want_issue = 1'b0;
    endcase
  end

  assign bidx        = issue_lane(state_q);
  // rst gating keeps the request low while reset is held.
  assign accept      = want_issue & ~bus.mem_busy & rst;
  assign fpc_inc_d   = fpc_q + 32'd4;
  assign redir_tgt_d = bus.redir_base + bus.redir_off;

  assign bus.mem_a  = fpc_q + {30'b0, bidx};
  assign bus.mem_re = accept;
  assign bus.is     = is_q;
  assign bus.pc     = pc_q;
  assign bus.vld    = vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= F0;
      fpc_q   <= RESET_PC;
      pend_q  <= 1'b0;
      pidx_q  <= '0;
      asm_q   <= '0;
      is_q    <= INSN_BUBBLE;
      pc_q    <= '0;
      vld_q   <= 1'b0;
    end else if (bus.redir_e) begin
      state_q <= F0;
      fpc_q   <= redir_tgt_d;
      pend_q  <= 1'b0;
      is_q    <= INSN_BUBBLE;
      pc_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      pend_q <= accept;
      if (accept) pidx_q <= bidx;

      // Byte 3 is never stored; it goes straight into the presented word.
      if (pend_q) begin
        case (pidx_q)
          2'd0:    asm_q[7:0]   <= bus.mem_din;
          2'd1:    asm_q[15:8]  <= bus.mem_din;
          2'd2:    asm_q[23:16] <= bus.mem_din;
          default: ;
        endcase
      end

      unique case (state_q)
        F0: if (accept) state_q <= F1;
        F1: if (accept) state_q <= F2;
        F2: if (accept) state_q <= F3;
        F3: if (accept) state_q <= CAP;
        CAP: begin
          if (pend_q && (pidx_q == 2'd3)) begin
            is_q    <= {bus.mem_din, asm_q};
            pc_q    <= fpc_inc_d;
            fpc_q   <= fpc_inc_d;
            vld_q   <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            is_q    <= INSN_BUBBLE;
            pc_q    <= '0;
            vld_q   <= 1'b0;
            state_q <= F0;
          end
        end
        default: state_q <= F0;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a word-level model predicts each presented
// instruction; a negedge monitor pops and compares. A second instance covers RESET_PC wrap.
module tb_if_fetch;
  import if_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_fetch_if bus  ();
  if_fetch_if wbus ();

  if_fetch #(.RESET_PC(32'h0000_0000)) u_dut  (.clk(clk), .rst(rst), .bus(bus.master));
  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst(rst), .bus(wbus.master));

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] is;
    logic [31:0] pc;
  } exp_t;

  exp_t        expq[$];
  exp_t        held_exp;
  logic [31:0] ea;
  logic [31:0] rdlog[$];
  logic [31:0] wrdlog[$];
  bit          prev_vld = 1'b0;
  int          pres = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void predict();
    exp_t e;
    e.is = word_at(ea);
    e.pc = ea + 32'd4;
    expq.push_back(e);
    ea = ea + 32'd4;
  endfunction

  // Byte memory with one-cycle read latency; junk when nothing was read.
  always @(posedge clk) begin
    bus.mem_din  <= bus.mem_re  ? mem_byte(bus.mem_a)  : 8'($urandom);
    wbus.mem_din <= wbus.mem_re ? mem_byte(wbus.mem_a) : 8'($urandom);
  end

  // Monitor + reference model; inputs only change just after posedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      expq.delete();
      rdlog.delete();
      wrdlog.delete();
      ea = 32'h0;
      predict();
      prev_vld = 1'b0;
    end else begin
      if (bus.mem_re)  rdlog.push_back(bus.mem_a);
      if (wbus.mem_re) wrdlog.push_back(wbus.mem_a);
      if (bus.mem_busy) chk("re_while_busy", {31'b0, bus.mem_re}, 32'd0);
      if (bus.vld) begin
        chk("re_while_presenting", {31'b0, bus.mem_re}, 32'd0);
        if (!prev_vld) begin
          pres++;
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: got is %h pc %h expected none", bus.is, bus.pc);
          end else begin
            e = expq.pop_front();
            chk("sb_is", bus.is, e.is);
            chk("sb_pc", bus.pc, e.pc);
            held_exp = e;
            predict();
          end
        end else begin
          chk("stall_is", bus.is, held_exp.is);
          chk("stall_pc", bus.pc, held_exp.pc);
        end
      end else begin
        chk("bubble_is", bus.is, INSN_BUBBLE);
        chk("bubble_pc", bus.pc, 32'd0);
      end
      prev_vld = bus.vld;
      if (bus.redir_e) begin
        expq.delete();
        ea = bus.redir_base + bus.redir_off;
        predict();
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rise(input int maxc, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.vld && n < maxc);
    chk("vld_wait", {31'b0, bus.vld}, 32'd1);
  endtask

  initial begin
    int n;
    int p0;
    logic [31:0] tgt;
    logic [31:0] lg;

    bus.stall = 0; bus.redir_e = 0; bus.redir_off = '0; bus.redir_base = '0; bus.mem_busy = 0;
    wbus.stall = 0; wbus.redir_e = 0; wbus.redir_off = '0; wbus.redir_base = '0; wbus.mem_busy = 0;
    rst = 0;
    step(2);

    chk("rst_vld", {31'b0, bus.vld}, 32'd0);
    chk("rst_is", bus.is, 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_re", {31'b0, bus.mem_re}, 32'd0);
    chk("rst_wrap_re", {31'b0, wbus.mem_re}, 32'd0);

    // Idle fetch from 0, plus wrap instance from FFFF_FFFC.
    rst = 1;
    wait_rise(30, n);
    chk("first_is", bus.is, 32'h0010_0513);
    chk("first_pc", bus.pc, 32'd4);
    chk("wrap_vld", {31'b0, wbus.vld}, 32'd1);
    chk("wrap_is", wbus.is, word_at(32'hFFFF_FFFC));
    chk("wrap_pc", wbus.pc, 32'd0);
    wait_rise(30, n);
    chk("period", n, 32'd6);
    for (int i = 0; i < 5; i++) begin
      lg = (rdlog.size() > i) ? rdlog[i] : 32'hDEAD_BEEF;
      chk("rd_addr", lg, i);
      lg = (wrdlog.size() > i) ? wrdlog[i] : 32'hDEAD_BEEF;
      chk("wrap_rd_addr", lg, 32'hFFFF_FFFC + i);
    end

    // mem_busy for three cycles while issuing byte 2 of the word at 8.
    step(3);
    chk("f2_addr", bus.mem_a, 32'd10);
    bus.mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_re", {31'b0, bus.mem_re}, 32'd0);
      chk("busy_addr", bus.mem_a, 32'd10);
      step(1);
    end
    bus.mem_busy = 0;
    wait_rise(30, n);
    chk("busy_period", n + 6, 32'd9);

    // Stall four cycles in HOLD.
    bus.stall = 1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stall_vld", {31'b0, bus.vld}, 32'd1);
      chk("stall_re", {31'b0, bus.mem_re}, 32'd0);
    end
    bus.stall = 0;
    step(1);
    chk("unstall_vld", {31'b0, bus.vld}, 32'd0);
    wait_rise(30, n);
    chk("stall_period", n + 5, 32'd10);
    lg = (rdlog.size() > 12) ? rdlog[12] : 32'hDEAD_BEEF;
    chk("resume_addr", lg, 32'd12);

    // Async reset while presenting, then while issuing.
    bus.stall = 1;
    rst = 0;
    #1;
    chk("arst_vld", {31'b0, bus.vld}, 32'd0);
    chk("arst_is", bus.is, 32'd0);
    chk("arst_re", {31'b0, bus.mem_re}, 32'd0);
    step(1);
    rst = 1;
    bus.stall = 0;
    step(1);
    chk("f1_re", {31'b0, bus.mem_re}, 32'd1);
    chk("f1_addr", bus.mem_a, 32'd1);
    rst = 0;
    #1;
    chk("arst_f1_re", {31'b0, bus.mem_re}, 32'd0);
    step(1);
    rst = 1;

    // JAL redirect in F2 while fetching 8.
    wait_rise(30, n);
    wait_rise(30, n);
    step(3);
    chk("jal_f2_addr", bus.mem_a, 32'd10);
    bus.redir_e = 1; bus.redir_base = 32'd4; bus.redir_off = 32'h10;
    step(1);
    bus.redir_e = 0;
    chk("jal_addr", bus.mem_a, 32'd20);
    chk("jal_re", {31'b0, bus.mem_re}, 32'd1);
    wait_rise(30, n);
    chk("jal_pc", bus.pc, 32'd24);

    // Redirect on the capture edge: completing word is dropped.
    step(5);
    tgt = 32'($urandom);
    bus.redir_e = 1; bus.redir_base = tgt; bus.redir_off = 32'h0000_0100;
    tgt = tgt + 32'h0000_0100;
    step(1);
    bus.redir_e = 0;
    chk("cap_redir_vld", {31'b0, bus.vld}, 32'd0);
    chk("cap_redir_is", bus.is, 32'd0);
    chk("cap_redir_addr", bus.mem_a, tgt);
    wait_rise(30, n);
    chk("cap_redir_pc", bus.pc, tgt + 32'd4);

    // Redirect while stalled in HOLD, target straddles the wrap.
    bus.stall = 1;
    bus.redir_e = 1; bus.redir_base = 32'hFFFF_FFF0; bus.redir_off = 32'h0000_000E;
    step(1);
    bus.stall = 0;
    bus.redir_e = 0;
    chk("hold_redir_vld", {31'b0, bus.vld}, 32'd0);
    chk("hold_redir_is", bus.is, 32'd0);
    chk("hold_redir_pc", bus.pc, 32'd0);
    chk("hold_redir_addr", bus.mem_a, 32'hFFFF_FFFE);
    wait_rise(30, n);
    chk("hold_redir_link", bus.pc, 32'd2);

    // Random busy/stall/redirect traffic, checked by the scoreboard.
    p0 = pres;
    for (int i = 0; i < 500; i++) begin
      bus.mem_busy = ($urandom_range(3) == 0);
      bus.stall    = ($urandom_range(9) < 3);
      bus.redir_e  = ($urandom_range(31) == 0);
      if ($urandom_range(1) == 0) bus.redir_base = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else                        bus.redir_base = 32'($urandom);
      bus.redir_off = 32'($urandom_range(64));
      step(1);
    end
    bus.mem_busy = 0; bus.stall = 0; bus.redir_e = 0;
    step(10);
    tests++;
    if (pres - p0 < 10) begin
      fails++;
      $display("FAIL rand_progress: got %0d words expected at least 10", pres - p0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
